// File: rtl/dbus_ctrl.sv
// Memory-stage data-bus controller: issues one load/store on a valid/data_ok bus and returns
// the lane-extracted, sign/zero-extended load result. Optional feature macro: MISALIGN_CHECK_EN.
`timescale 1ns/1ps
module dbus_ctrl #(
   parameter int unsigned AW = 64
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_store,
   input  logic [AW-1:0] in_addr,
   input  logic [1:0]    in_size,
   input  logic          in_unsigned,
   input  logic [63:0]   in_wd,
   input  logic [7:0]    in_strobe,
   input  logic          flush,
   output logic          dbus_valid,
   output logic [AW-1:0] dbus_addr,
   output logic [1:0]    dbus_size,
   output logic [7:0]    dbus_strobe,
   output logic [63:0]   dbus_wdata,
   input  logic          dbus_data_ok,
   input  logic [63:0]   dbus_rdata,
   output logic          out_valid,
   output logic [63:0]   out_rdata,
   output logic          out_misalign
);

   typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

   state_e      state_q;
   logic        is_store_q;
   logic        ld_unsigned_q;
   logic        accept;
   logic        misalign;
   logic [2:0]  shamt;
   logic [63:0] lane;
   logic [63:0] load_ext;

   assign in_ready = (state_q == StIdle);
   assign accept   = in_ready & in_valid & ~flush;

`ifdef MISALIGN_CHECK_EN
   always_comb begin
      unique case (in_size)
         2'd1:    misalign = in_addr[0];
         2'd2:    misalign = |in_addr[1:0];
         2'd3:    misalign = |in_addr[2:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // Lane offset is the latched address rounded down to the access size.
   always_comb begin
      unique case (dbus_size)
         2'd0:    shamt = dbus_addr[2:0];
         2'd1:    shamt = {dbus_addr[2:1], 1'b0};
         2'd2:    shamt = {dbus_addr[2], 2'b00};
         default: shamt = 3'd0;
      endcase
      lane = dbus_rdata >> {shamt, 3'b000};
      unique case (dbus_size)
         2'd0:    load_ext = {{56{~ld_unsigned_q & lane[7]}}, lane[7:0]};
         2'd1:    load_ext = {{48{~ld_unsigned_q & lane[15]}}, lane[15:0]};
         2'd2:    load_ext = {{32{~ld_unsigned_q & lane[31]}}, lane[31:0]};
         default: load_ext = lane;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         is_store_q    <= 1'b0;
         ld_unsigned_q <= 1'b0;
         dbus_valid    <= 1'b0;
         dbus_addr     <= '0;
         dbus_size     <= 2'd0;
         dbus_strobe   <= 8'h00;
         dbus_wdata    <= 64'd0;
         out_valid     <= 1'b0;
         out_rdata     <= 64'd0;
         out_misalign  <= 1'b0;
      end else begin
         out_valid    <= 1'b0;
         out_misalign <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (misalign) begin
                     out_valid    <= 1'b1;
                     out_misalign <= 1'b1;
                     out_rdata    <= 64'd0;
                  end else begin
                     state_q       <= StWait;
                     dbus_valid    <= 1'b1;
                     dbus_addr     <= in_addr;
                     dbus_size     <= in_size;
                     dbus_strobe   <= in_store ? in_strobe : 8'h00;
                     dbus_wdata    <= in_wd;
                     is_store_q    <= in_store;
                     ld_unsigned_q <= in_unsigned;
                  end
               end
            end
            StWait: begin
               if (dbus_data_ok) begin
                  state_q    <= StIdle;
                  dbus_valid <= 1'b0;
                  if (!flush) begin
                     out_valid <= 1'b1;
                     out_rdata <= is_store_q ? 64'd0 : load_ext;
                  end
               end else if (flush) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               // Request stays on the bus until it completes; its result is dropped.
               if (dbus_data_ok) begin
                  state_q    <= StIdle;
                  dbus_valid <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: table-driven load/store vectors with a result scoreboard,
// plus hand-written flush, back-to-back, misalign and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_dbus_ctrl;
   localparam int unsigned AW = 64;
   localparam logic [63:0] R = 64'h8877_6655_4433_2211;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid, in_ready, in_store, in_unsigned, flush;
   logic [AW-1:0] in_addr;
   logic [1:0]    in_size;
   logic [63:0]   in_wd;
   logic [7:0]    in_strobe;
   logic          dbus_valid, dbus_data_ok;
   logic [AW-1:0] dbus_addr;
   logic [1:0]    dbus_size;
   logic [7:0]    dbus_strobe;
   logic [63:0]   dbus_wdata, dbus_rdata;
   logic          out_valid, out_misalign;
   logic [63:0]   out_rdata;

   always #5 clk = ~clk;

   dbus_ctrl #(.AW(AW)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_store(in_store), .in_addr(in_addr), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_wd(in_wd), .in_strobe(in_strobe), .flush(flush), .dbus_valid(dbus_valid),
      .dbus_addr(dbus_addr), .dbus_size(dbus_size), .dbus_strobe(dbus_strobe),
      .dbus_wdata(dbus_wdata), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
      .out_valid(out_valid), .out_rdata(out_rdata), .out_misalign(out_misalign)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        misalign;
      logic        chk_data;
   } exp_t;

   typedef struct {
      logic        st;
      logic [63:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] wd;
      logic [7:0]  strobe;
      logic [63:0] rdata;
      int          dly;
      logic [63:0] exp;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[11];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every completion pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (resetn === 1'b1 && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out_valid: got out_valid=1, expected 0");
         end else begin
            mon_e = sb.pop_front();
            chk("out_misalign", {63'd0, out_misalign}, {63'd0, mon_e.misalign});
            if (mon_e.chk_data) chk("out_rdata", out_rdata, mon_e.rdata);
         end
      end
   end

   task automatic run_txn(input vec_t v);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; in_store = v.st; in_addr = v.addr; in_size = v.size;
      in_unsigned = v.uns; in_wd = v.wd; in_strobe = v.strobe;
      sb.push_back('{rdata: v.exp, misalign: 1'b0, chk_data: 1'b1});
      @(posedge clk); #1;
      // Scramble live inputs: results must come from the latched request.
      in_valid = 1'b0; in_store = ~v.st; in_addr = ~v.addr; in_size = ~v.size;
      in_unsigned = ~v.uns; in_wd = ~v.wd; in_strobe = ~v.strobe;
      chk("dbus_valid", {63'd0, dbus_valid}, 64'd1);
      chk("dbus_addr", dbus_addr, v.addr);
      chk("dbus_size", {62'd0, dbus_size}, {62'd0, v.size});
      chk("dbus_strobe", {56'd0, dbus_strobe}, {56'd0, (v.st ? v.strobe : 8'h00)});
      for (int i = 0; i < v.dly; i++) begin
         @(posedge clk); #1;
         chk("dbus_valid_hold", {63'd0, dbus_valid}, 64'd1);
         chk("dbus_addr_hold", dbus_addr, v.addr);
         if (v.st) chk("dbus_wdata_hold", dbus_wdata, v.wd);
      end
      dbus_data_ok = 1'b1; dbus_rdata = v.rdata;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0; dbus_rdata = {$urandom, $urandom};
      chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
      chk("dbus_valid_drop", {63'd0, dbus_valid}, 64'd0);
      chk("in_ready_after", {63'd0, in_ready}, 64'd1);
      @(negedge clk); #1;
      chk("sb_popped", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
      chk("out_valid_pulse", {63'd0, out_valid}, 64'd0);
   endtask

   task automatic drive_load(input logic [63:0] addr, input logic [1:0] size, input logic uns);
      in_valid = 1'b1; in_store = 1'b0; in_addr = addr; in_size = size;
      in_unsigned = uns; in_wd = 64'd0; in_strobe = 8'h00;
   endtask

   initial begin
      vecs[0]  = '{st:0, addr:64'h1000, size:3, uns:0, wd:0, strobe:0, rdata:R, dly:3, exp:R};
      vecs[1]  = '{st:0, addr:64'h1005, size:0, uns:0, wd:0, strobe:0,
                   rdata:64'h0000_8000_0000_0000, dly:0, exp:64'hFFFF_FFFF_FFFF_FF80};
      vecs[2]  = '{st:0, addr:64'h1005, size:0, uns:1, wd:0, strobe:0,
                   rdata:64'h0000_8000_0000_0000, dly:1, exp:64'h80};
      vecs[3]  = '{st:1, addr:64'h1006, size:1, uns:0, wd:64'hBEEF_0000_0000_0000,
                   strobe:8'hC0, rdata:R, dly:2, exp:64'd0};
      vecs[4]  = '{st:0, addr:64'h2006, size:1, uns:0, wd:0, strobe:0, rdata:R, dly:0,
                   exp:64'hFFFF_FFFF_FFFF_8877};
      vecs[5]  = '{st:0, addr:64'h2004, size:2, uns:1, wd:0, strobe:0, rdata:R, dly:1,
                   exp:64'h0000_0000_8877_6655};
      vecs[6]  = '{st:0, addr:64'h2004, size:2, uns:0, wd:0, strobe:0, rdata:R, dly:2,
                   exp:64'hFFFF_FFFF_8877_6655};
      vecs[7]  = '{st:0, addr:64'h2000, size:2, uns:0, wd:0, strobe:0, rdata:R, dly:3,
                   exp:64'h0000_0000_4433_2211};
      vecs[8]  = '{st:0, addr:64'h3000, size:0, uns:1, wd:0, strobe:0, rdata:R, dly:1, exp:64'h11};
      vecs[9]  = '{st:0, addr:64'h3002, size:1, uns:1, wd:0, strobe:0, rdata:R, dly:0,
                   exp:64'h4433};
      vecs[10] = '{st:1, addr:64'h4000, size:3, uns:0, wd:64'h0123_4567_89AB_CDEF,
                   strobe:8'hFF, rdata:R, dly:0, exp:64'd0};

      resetn = 1'b0; in_valid = 1'b0; in_store = 1'b0; in_addr = '0; in_size = 2'd0;
      in_unsigned = 1'b0; in_wd = 64'd0; in_strobe = 8'h00; flush = 1'b0;
      dbus_data_ok = 1'b0; dbus_rdata = 64'd0;
      #2;
      chk("rst_dbus_valid", {63'd0, dbus_valid}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_misalign", {63'd0, out_misalign}, 64'd0);
      chk("rst_dbus_addr", dbus_addr, 64'd0);
      chk("rst_dbus_strobe", {56'd0, dbus_strobe}, 64'd0);
      chk("rst_dbus_wdata", dbus_wdata, 64'd0);
      chk("rst_out_rdata", out_rdata, 64'd0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_txn(vecs[i]);

      // Flush one cycle after accept, completion two cycles later: request held, result dropped.
      drive_load(64'h6000, 2'd3, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("flush_dbus_valid", {63'd0, dbus_valid}, 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("drain_hold1", {63'd0, dbus_valid}, 64'd1);
      chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
      chk("drain_hold2", {63'd0, dbus_valid}, 64'd1);
      dbus_data_ok = 1'b1; dbus_rdata = R;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0;
      chk("drain_drop", {63'd0, dbus_valid}, 64'd0);
      chk("drain_no_out", {63'd0, out_valid}, 64'd0);
      chk("drain_in_ready_after", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;

      // Flush and completion in the same cycle.
      drive_load(64'h6008, 2'd3, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b1; dbus_data_ok = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; dbus_data_ok = 1'b0;
      chk("flushok_dbus_valid", {63'd0, dbus_valid}, 64'd0);
      chk("flushok_no_out", {63'd0, out_valid}, 64'd0);
      chk("flushok_in_ready", {63'd0, in_ready}, 64'd1);

      // Request with flush in idle is refused; data_ok in idle is ignored.
      drive_load(64'h6010, 2'd3, 1'b0);
      flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      chk("idle_flush_refused", {63'd0, dbus_valid}, 64'd0);
      dbus_data_ok = 1'b1;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0;
      chk("idle_dataok_ignored", {63'd0, out_valid}, 64'd0);
      chk("idle_dataok_no_bus", {63'd0, dbus_valid}, 64'd0);

      // Back-to-back loads with data_ok in the first dbus_valid cycle.
      drive_load(64'h7004, 2'd2, 1'b1);
      sb.push_back('{rdata: 64'h8877_6655, misalign: 1'b0, chk_data: 1'b1});
      @(posedge clk); #1;
      chk("b2b_a_issued", {63'd0, dbus_valid}, 64'd1);
      dbus_data_ok = 1'b1; dbus_rdata = R;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0;
      chk("b2b_a_out", {63'd0, out_valid}, 64'd1);
      chk("b2b_ready", {63'd0, in_ready}, 64'd1);
      chk("b2b_gap", {63'd0, dbus_valid}, 64'd0);
      drive_load(64'h7007, 2'd0, 1'b0);
      sb.push_back('{rdata: 64'hFFFF_FFFF_FFFF_FF88, misalign: 1'b0, chk_data: 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_b_issued", {63'd0, dbus_valid}, 64'd1);
      chk("b2b_b_addr", dbus_addr, 64'h7007);
      dbus_data_ok = 1'b1; dbus_rdata = R;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0;
      chk("b2b_b_out", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;

      // 4-byte load at a 2-byte offset.
      drive_load(64'h5002, 2'd2, 1'b0);
`ifdef MISALIGN_CHECK_EN
      sb.push_back('{rdata: 64'd0, misalign: 1'b1, chk_data: 1'b1});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mis_no_bus", {63'd0, dbus_valid}, 64'd0);
      chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
      chk("mis_flag", {63'd0, out_misalign}, 64'd1);
      chk("mis_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      chk("mis_no_bus_later", {63'd0, dbus_valid}, 64'd0);
      chk("mis_flag_pulse", {63'd0, out_misalign}, 64'd0);
`else
      sb.push_back('{rdata: 64'd0, misalign: 1'b0, chk_data: 1'b0});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mis_issued", {63'd0, dbus_valid}, 64'd1);
      dbus_data_ok = 1'b1; dbus_rdata = R;
      @(posedge clk); #1;
      dbus_data_ok = 1'b0;
      chk("mis_out_valid", {63'd0, out_valid}, 64'd1);
      chk("mis_flag", {63'd0, out_misalign}, 64'd0);
      @(posedge clk); #1;
`endif

      // Asynchronous reset mid-transaction drops the bus request without a clock edge.
      drive_load(64'h8000, 2'd3, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("arst_pre", {63'd0, dbus_valid}, 64'd1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_drop", {63'd0, dbus_valid}, 64'd0);
      chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
      chk("arst_idle", {63'd0, dbus_valid}, 64'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
